// File: rtl/fir_axil_regs.sv
// AXI4-Lite register file for the FIR block: NUM_REGS 32-bit control/status registers,
// exposed in parallel on reg_out, with a one-cycle write strobe per register on commit.
module fir_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [NUM_REGS*32-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int NB    = DW / 8;

    logic             rst_rel_q;
    logic             aw_held_q, aw_held_d;
    logic             w_held_q, w_held_d;
    logic [IDX_W-1:0] awidx_q, awidx_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [NB-1:0]    wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [NUM_REGS-1:0] pulse_q, pulse_d;
    logic [DW-1:0]    regs_q [NUM_REGS];
    logic [DW-1:0]    regs_d [NUM_REGS];

    logic             aw_hs_s, w_hs_s, ar_hs_s;
    logic [IDX_W-1:0] aridx_s;
    logic             unused_s;

    assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // rst_rel_q keeps every ready low through reset and for the edge that releases it
    assign s_axi_awready = !aw_held_q && !bvalid_q && !rst_rel_q;
    assign s_axi_wready  = !w_held_q && !bvalid_q && !rst_rel_q;
    assign s_axi_arready = !rvalid_q && !rst_rel_q;
    assign aw_hs_s = s_axi_awvalid && s_axi_awready;
    assign w_hs_s  = s_axi_wvalid && s_axi_wready;
    assign ar_hs_s = s_axi_arvalid && s_axi_arready;
    assign aridx_s = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign reg_wr_pulse = pulse_q;

    // Flatten the register file onto the parallel output bus
    always_comb begin
        reg_out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_out[32*k +: 32] = regs_q[k];
        end
    end

    // Next-state: AW/W capture, write commit, B and R handshakes
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        pulse_d   = '0;
        regs_d    = regs_q;

        if (aw_hs_s) begin
            aw_held_d = 1'b1;
            awidx_d   = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        end else begin
            aw_held_d = aw_held_q;
        end
        if (w_hs_s) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end else begin
            w_held_d = w_held_q;
        end

        // Both halves captured: commit and raise the response in one edge
        if (aw_held_q && w_held_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if ({1'b0, awidx_q} < (IDX_W+1)'(NUM_REGS)) begin
                bresp_d = 2'b00;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (awidx_q == IDX_W'(k)) begin
                        pulse_d[k] = 1'b1;
                        for (int b = 0; b < NB; b++) begin
                            if (wstrb_q[b]) begin
                                regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                            end else begin
                                regs_d[k][8*b +: 8] = regs_q[k][8*b +: 8];
                            end
                        end
                    end else begin
                        pulse_d[k] = 1'b0;
                    end
                end
            end else begin
                bresp_d = 2'b10;
            end
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        // Read data comes from regs_q, so a same-edge write is not yet visible
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            if ({1'b0, aridx_s} < (IDX_W+1)'(NUM_REGS)) begin
                rresp_d = 2'b00;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (aridx_s == IDX_W'(k)) begin
                        rdata_d = regs_q[k];
                    end else begin
                        rdata_d = rdata_d;
                    end
                end
            end else begin
                rresp_d = 2'b10;
            end
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_rel_q <= 1'b1;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            pulse_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            rst_rel_q <= 1'b0;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            pulse_q   <= pulse_d;
            regs_q    <= regs_d;
        end
    end
endmodule

// File: tb/tb_fir_axil_regs.sv
// Directed self-checking bench for fir_axil_regs: inputs driven and outputs sampled on the
// falling edge, expected values written out by hand.
module tb_fir_axil_regs;
    logic         clock = 1'b0;
    logic         reset;
    logic [4:0]   s_axi_awaddr, s_axi_araddr;
    logic [2:0]   s_axi_awprot, s_axi_arprot;
    logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0]  s_axi_wdata, s_axi_rdata;
    logic [3:0]   s_axi_wstrb;
    logic [1:0]   s_axi_bresp, s_axi_rresp;
    logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic         s_axi_rvalid, s_axi_rready;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt [4] = '{0, 0, 0, 0};

    fir_axil_regs dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clock = ~clock;

    // Count strobe cycles per register; a stretched pulse shows up as an extra count
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (reg_wr_pulse[k]) pulse_cnt[k]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [4:0] a);
        int n = 0;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 20) begin @(negedge clock); n++; end
        check("aw_wait", 128'(n < 20), 128'd1);
        @(negedge clock); s_axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 20) begin @(negedge clock); n++; end
        check("w_wait", 128'(n < 20), 128'd1);
        @(negedge clock); s_axi_wvalid = 1'b0;
    endtask

    task automatic aw_w_send(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic ah, wh;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
            ah = s_axi_awvalid && s_axi_awready;
            wh = s_axi_wvalid && s_axi_wready;
            @(negedge clock); n++;
            if (ah) s_axi_awvalid = 1'b0;
            if (wh) s_axi_wvalid = 1'b0;
        end
        check("aww_wait", 128'(n < 20), 128'd1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] r);
        int n = 0;
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && n < 20) begin @(negedge clock); n++; end
        check("b_wait", 128'(n < 20), 128'd1);
        r = s_axi_bresp;
        @(negedge clock); s_axi_bready = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        aw_w_send(a, d, s);
        b_recv(r);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 20) begin @(negedge clock); n++; end
        @(negedge clock); s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        while (!s_axi_rvalid && n < 40) begin @(negedge clock); n++; end
        check("r_wait", 128'(n < 40), 128'd1);
        d = s_axi_rdata; r = s_axi_rresp;
        @(negedge clock); s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [1:0]   r;
        logic [31:0]  d;
        logic [127:0] saved;
        int           psum;
        int           n;

        reset = 1'b1;
        s_axi_awaddr = 5'h00; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b0;
        s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = 5'h00; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ready", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'd0);
        check("rst_valid", 128'({s_axi_bvalid, s_axi_rvalid}), 128'd0);
        check("rst_resp", 128'({s_axi_bresp, s_axi_rresp, s_axi_rdata}), 128'd0);
        check("rst_regs", reg_out, 128'd0);
        check("rst_pulse", 128'(reg_wr_pulse), 128'd0);
        reset = 1'b0;
        check("rel_ready_low", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'd0);
        @(negedge clock);
        check("rel_ready_high", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'h7);

        // Basic write-then-read of all four registers
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4*i), 32'(i + 1), 4'hF, r);
            check("wr_bresp", 128'(r), 128'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4*i), d, r);
            check("rd_data", 128'(d), 128'(i + 1));
            check("rd_rresp", 128'(r), 128'd0);
        end
        check("reg_out_basic", reg_out, {32'd4, 32'd3, 32'd2, 32'd1});
        for (int k = 0; k < 4; k++) check("pulse_basic", 128'(pulse_cnt[k]), 128'd1);

        // AW three cycles ahead of W, then W three cycles ahead of AW
        aw_send(5'h08);
        repeat (2) @(negedge clock);
        w_send(32'hA5A5A5A5, 4'hF);
        check("b_early_awfirst", 128'(s_axi_bvalid), 128'd0);
        @(negedge clock);
        check("b_rise_awfirst", 128'(s_axi_bvalid), 128'd1);
        b_recv(r);
        check("bresp_awfirst", 128'(r), 128'd0);
        check("reg2_awfirst", 128'(reg_out[95:64]), 128'hA5A5A5A5);
        w_send(32'hA5A5A5A5, 4'hF);
        repeat (2) @(negedge clock);
        aw_send(5'h08);
        check("b_early_wfirst", 128'(s_axi_bvalid), 128'd0);
        @(negedge clock);
        check("b_rise_wfirst", 128'(s_axi_bvalid), 128'd1);
        b_recv(r);
        check("reg2_wfirst", 128'(reg_out[95:64]), 128'hA5A5A5A5);
        check("pulse_reg2", 128'(pulse_cnt[2]), 128'd3);

        // Partial byte strobes
        axi_write(5'h04, 32'h11223344, 4'hF, r);
        axi_write(5'h04, 32'hAABBCCDD, 4'b0101, r);
        check("strb_bresp", 128'(r), 128'd0);
        check("strb_reg1", 128'(reg_out[63:32]), 128'h11BB33DD);
        axi_read(5'h04, d, r);
        check("strb_read", 128'(d), 128'h11BB33DD);
        check("pulse_reg1", 128'(pulse_cnt[1]), 128'd3);

        // Back-pressure on B and R
        aw_w_send(5'h0C, 32'hDEADBEEF, 4'hF);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            check("bstall_valid", 128'({s_axi_bvalid, s_axi_bresp}), 128'b100);
            check("bstall_ready", 128'({s_axi_awready, s_axi_wready}), 128'd0);
            @(negedge clock);
        end
        b_recv(r);
        check("bstall_resp", 128'(r), 128'd0);
        s_axi_araddr = 5'h0C; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 20) begin @(negedge clock); n++; end
        @(negedge clock); s_axi_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rstall_valid", 128'({s_axi_rvalid, s_axi_rresp}), 128'b100);
            check("rstall_data", 128'(s_axi_rdata), 128'hDEADBEEF);
            check("rstall_arready", 128'(s_axi_arready), 128'd0);
            @(negedge clock);
        end
        s_axi_rready = 1'b1;
        @(negedge clock); s_axi_rready = 1'b0;
        check("rstall_drop", 128'(s_axi_rvalid), 128'd0);

        // Out-of-range accesses
        saved = reg_out;
        psum = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, r);
        check("oor_bresp", 128'(r), 128'd2);
        axi_read(5'h14, d, r);
        check("oor_rresp", 128'(r), 128'd2);
        check("oor_rdata", 128'(d), 128'd0);
        check("oor_regs", reg_out, saved);
        check("oor_pulse", 128'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 128'(psum));

        // Reset with a held AW and a pending R
        aw_send(5'h00);
        s_axi_araddr = 5'h0C; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 20) begin @(negedge clock); n++; end
        @(negedge clock); s_axi_arvalid = 1'b0;
        check("pre_rst_rvalid", 128'(s_axi_rvalid), 128'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_valid", 128'({s_axi_bvalid, s_axi_rvalid, s_axi_rdata, s_axi_rresp}), 128'd0);
        check("mid_rst_ready", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'd0);
        check("mid_rst_regs", reg_out, 128'd0);
        reset = 1'b0;
        @(negedge clock);
        w_send(32'h00000077, 4'hF);
        repeat (3) begin
            @(negedge clock);
            check("no_stale_b", 128'(s_axi_bvalid), 128'd0);
        end
        aw_send(5'h00);
        b_recv(r);
        axi_write(5'h00, 32'h5A5A0001, 4'hF, r);
        check("post_rst_bresp", 128'(r), 128'd0);
        axi_read(5'h00, d, r);
        check("post_rst_read", 128'(d), 128'h5A5A0001);
        check("post_rst_regs", reg_out, {96'd0, 32'h5A5A0001});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
